// File: rtl/hypiu_seq_core.sv
// hypiu_seq_core: multi-cycle fetch/execute sequencer driving an external register file and clocked ALU.
// Defining HYPIU_SEQ_SINGLE_STEP_EN adds the step_i port and a PAUSE state after every retired instruction.
module hypiu_seq_core #(
  parameter int              DATA_W   = 16,
  parameter int              REG_AW   = 3,
  parameter int              PC_W     = 16,
  parameter int              ALU_OP_W = 3,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                run_i,
`ifdef HYPIU_SEQ_SINGLE_STEP_EN
  input  logic                step_i,
`endif
  output logic                imem_req_o,
  output logic [PC_W-1:0]     imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [DATA_W-1:0]   imem_data_i,
  output logic [REG_AW-1:0]   addr_a_o,
  output logic [REG_AW-1:0]   addr_b_o,
  output logic [REG_AW-1:0]   addr_w_o,
  output logic                en_a_o,
  output logic                en_b_o,
  output logic                en_w_o,
  output logic                en_d_o,
  output logic [DATA_W-1:0]   bus_d_o,
  output logic [ALU_OP_W-1:0] alu_oper_o,
  input  logic                z_flag_i,
  output logic [PC_W-1:0]     pc_o,
  output logic                halted_o,
  output logic                illegal_o
);

  // state    | meaning
  // IDLE     | waiting for run_i
  // FETCH    | instruction fetch at pc, wait for ack
  // EXEC     | ALU read/operate, or decode of LDI/BZ/JMP/HALT/illegal
  // WB       | register write (ALU result or LDI immediate)
  // FETCH_OP | fetch of the LDI/BZ/JMP operand word
  // HALT     | stopped until reset
  // PAUSE    | single-step hold after a retired instruction
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WB, S_FETCH_OP, S_HALT, S_PAUSE
  } state_e;

  localparam int IR_W = 4 + 3 * REG_AW;

`ifdef HYPIU_SEQ_SINGLE_STEP_EN
  localparam state_e S_RETIRE = S_PAUSE;
`else
  localparam state_e S_RETIRE = S_FETCH;
`endif

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] opd_q, opd_d;
  logic              z_q, z_d;
  logic              ill_q, ill_d;

  logic [3:0]        op;
  logic [REG_AW-1:0] rw, ra, rb;
  logic              is_alu, is_ldi, is_bz, is_jmp, is_halt, is_ill;
  logic [PC_W-1:0]   pc_inc;

  assign op      = ir_q[IR_W-1 -: 4];
  assign rw      = ir_q[IR_W-5 -: REG_AW];
  assign ra      = ir_q[IR_W-5-REG_AW -: REG_AW];
  assign rb      = ir_q[REG_AW-1:0];
  assign is_alu  = ~op[3];
  assign is_ldi  = (op == 4'h8);
  assign is_bz   = (op == 4'h9);
  assign is_jmp  = (op == 4'hA);
  assign is_halt = (op == 4'hF);
  assign is_ill  = op[3] & ~is_ldi & ~is_bz & ~is_jmp & ~is_halt;
  assign pc_inc  = pc_q + PC_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (run_i) state_d = S_FETCH;
      S_FETCH:    if (imem_ack_i) state_d = S_EXEC;
      S_EXEC: begin
        if (is_alu)                            state_d = S_WB;
        else if (is_ldi || is_bz || is_jmp)    state_d = S_FETCH_OP;
        else                                   state_d = S_HALT;
      end
      S_WB:       state_d = S_RETIRE;
      S_FETCH_OP: if (imem_ack_i) state_d = is_ldi ? S_WB : S_RETIRE;
      S_HALT:     state_d = S_HALT;
`ifdef HYPIU_SEQ_SINGLE_STEP_EN
      S_PAUSE:    if (step_i) state_d = S_FETCH;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    addr_a_o    = '0;
    addr_b_o    = '0;
    addr_w_o    = '0;
    en_a_o      = 1'b0;
    en_b_o      = 1'b0;
    en_w_o      = 1'b0;
    en_d_o      = 1'b0;
    bus_d_o     = '0;
    alu_oper_o  = '0;
    halted_o    = 1'b0;
    case (state_q)
      S_FETCH, S_FETCH_OP: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
      end
      S_EXEC: begin
        if (is_alu) begin
          en_a_o     = 1'b1;
          en_b_o     = 1'b1;
          addr_a_o   = ra;
          addr_b_o   = rb;
          alu_oper_o = ALU_OP_W'(op);
        end
      end
      S_WB: begin
        en_w_o   = 1'b1;
        addr_w_o = rw;
        if (is_ldi) begin
          en_d_o  = 1'b1;
          bus_d_o = opd_q;
        end
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: PC, instruction, operand word, zero flag copy, sticky illegal.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    opd_d = opd_q;
    z_d   = z_q;
    ill_d = ill_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack_i) begin
          ir_d = imem_data_i[DATA_W-1 -: IR_W];
          pc_d = pc_inc;
        end
      end
      S_FETCH_OP: begin
        if (imem_ack_i) begin
          opd_d = imem_data_i;
          pc_d  = (is_jmp || (is_bz && z_q)) ? PC_W'(imem_data_i) : pc_inc;
        end
      end
      S_WB:    if (is_alu) z_d = z_flag_i;
      S_EXEC:  if (is_ill) ill_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      opd_q <= '0;
      z_q   <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      opd_q <= opd_d;
      z_q   <= z_d;
      ill_q <= ill_d;
    end
  end

  assign pc_o      = pc_q;
  assign illegal_o = ill_q;

endmodule

// File: tb/tb_hypiu_seq_core.sv
// Bench for hypiu_seq_core: directed programs plus random programs checked by an ISA-level model.
module tb_hypiu_seq_core;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int PC_W   = 16;
  localparam int OP_W   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              run = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack = 1'b0;
  logic [DATA_W-1:0] imem_data = '0;
  logic [REG_AW-1:0] addr_a, addr_b, addr_w;
  logic              en_a, en_b, en_w, en_d;
  logic [DATA_W-1:0] bus_d;
  logic [OP_W-1:0]   alu_oper;
  logic              z_flag = 1'b0;
  logic [PC_W-1:0]   pc;
  logic              halted, illegal;

  hypiu_seq_core #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .ALU_OP_W(OP_W), .RESET_PC(16'h0000)
  ) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .addr_a_o(addr_a), .addr_b_o(addr_b), .addr_w_o(addr_w),
    .en_a_o(en_a), .en_b_o(en_b), .en_w_o(en_w), .en_d_o(en_d),
    .bus_d_o(bus_d), .alu_oper_o(alu_oper), .z_flag_i(z_flag),
    .pc_o(pc), .halted_o(halted), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction memory: 256 words, address aliased on the low byte.
  logic [15:0] mem [256];
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem[a[7:0]];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  // Memory responder and z_flag driver settings.
  int ack_min = 0, ack_max = 0, ack_cnt = -1;
  bit z_rand = 1'b1;
  logic z_fix = 1'b0;

  // ISA-level reference model state and observation records.
  logic [15:0] m_pc;
  logic        m_z, m_opnd, m_stop;
  logic [3:0]  m_cur;
  logic        exp_rd, exp_wr, e_imm;
  logic [2:0]  e_ra, e_rb, e_rw, e_op;
  logic [15:0] e_bus;
  int          tick_n = 0, wr_cnt = 0, rd_cnt = 0, ack_tick = 0, wr_tick = 0, jmp_tick = 0;
  bit          jmp_done;
  logic [2:0]  last_waddr, last_ra, last_rb, last_op;
  logic [15:0] last_bus;
  logic        last_en_d;

  task automatic model_reset();
    m_pc = 16'h0000; m_z = 1'b0; m_opnd = 1'b0; m_stop = 1'b0; m_cur = 4'h0;
    exp_rd = 1'b0; exp_wr = 1'b0; e_imm = 1'b0;
    wr_cnt = 0; rd_cnt = 0; jmp_done = 1'b0; ack_cnt = -1;
  endtask

  task automatic drive_inputs();
    z_flag = z_rand ? 1'($urandom_range(1, 0)) : z_fix;
    imem_ack = 1'b0;
    imem_data = 16'($urandom);
    if (imem_req) begin
      if (ack_cnt < 0) ack_cnt = $urandom_range(ack_max, ack_min);
      if (ack_cnt == 0) begin
        imem_ack = 1'b1;
        imem_data = mem_rd(imem_addr);
        ack_cnt = -1;
      end else ack_cnt--;
    end else ack_cnt = -1;
  endtask

  task automatic monitor();
    logic [15:0] w;
    logic [3:0]  op;
    if (reset) return;
    check_eq("pc", pc, m_pc);
    if (imem_req) check_eq("imem_addr", imem_addr, m_pc);
    if (halted) check_eq("req_in_halt", imem_req, 0);
    if (en_a || en_b) begin
      check_eq("rd_expected", exp_rd, 1);
      check_eq("en_ab_pair", {en_a, en_b}, 2'b11);
      check_eq("addr_a", addr_a, e_ra);
      check_eq("addr_b", addr_b, e_rb);
      check_eq("alu_oper", alu_oper, e_op);
      last_ra = addr_a; last_rb = addr_b; last_op = alu_oper;
      exp_rd = 1'b0; rd_cnt++;
    end
    if (en_w) begin
      check_eq("wr_expected", exp_wr, 1);
      check_eq("wr_rd_excl", en_a | en_b, 0);
      check_eq("rd_before_wr", exp_rd, 0);
      check_eq("addr_w", addr_w, e_rw);
      check_eq("en_d", en_d, e_imm);
      if (e_imm) check_eq("bus_d", bus_d, e_bus);
      else m_z = z_flag;
      last_waddr = addr_w; last_bus = bus_d; last_en_d = en_d;
      exp_wr = 1'b0; wr_cnt++; wr_tick = tick_n;
    end else check_eq("en_d_alone", en_d, 0);
    if (imem_req && imem_ack) begin
      check_eq("fetch_after_stop", m_stop, 0);
      check_eq("events_pending", exp_rd | exp_wr, 0);
      w = mem_rd(m_pc);
      m_pc = m_pc + 16'd1;
      if (!m_opnd) begin
        op = w[15:12];
        ack_tick = tick_n;
        e_rw = w[11:9]; e_ra = w[8:6]; e_rb = w[5:3];
        if (op < 4'h8) begin
          exp_rd = 1'b1; exp_wr = 1'b1; e_imm = 1'b0; e_op = op[2:0];
        end else if (op <= 4'hA) begin
          m_opnd = 1'b1; m_cur = op;
        end else m_stop = 1'b1;
      end else begin
        m_opnd = 1'b0;
        if (m_cur == 4'h8) begin
          exp_wr = 1'b1; e_imm = 1'b1; e_bus = w;
        end else begin
          if (m_cur == 4'hA || m_z) m_pc = w;
          jmp_done = 1'b1; jmp_tick = tick_n;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drive_inputs();
    monitor();
    tick_n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (wr_cnt < n && k < budget) begin tick(); k++; end
    check_eq("wr_timeout", wr_cnt >= n, 1);
  endtask

  task automatic wait_jmp(input int budget);
    int k = 0;
    while (!jmp_done && k < budget) begin tick(); k++; end
    check_eq("jmp_timeout", jmp_done, 1);
  endtask

  // ALU-op with z_flag forced, then BZ #0x0040; returns via checks on pc.
  task automatic bz_case(input logic zv, input logic [15:0] exp_pc);
    clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h9000; mem[2] = 16'h0040;
    ack_min = 0; ack_max = 0; z_rand = 1'b0; z_fix = zv;
    do_reset();
    run = 1'b1;
    wait_jmp(40);
    check_eq("bz_lat", jmp_tick - ack_tick + 1, 3);
    tick();
    check_eq("bz_pc", pc, exp_pc);
    z_rand = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_mem();

    // Idle after reset
    do_reset();
    repeat (10) tick();
    check_eq("rst_pc", pc, 0);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_en", {en_a, en_b, en_w, en_d}, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_illegal", illegal, 0);

    // ALU op 1, rw=2 ra=3 rb=4, zero-wait ack
    clear_mem();
    mem[0] = 16'h14E0;
    do_reset();
    run = 1'b1;
    wait_wr(1, 30);
    check_eq("alu_lat", wr_tick - ack_tick + 1, 3);
    check_eq("alu_rd", {last_ra, last_rb, last_op}, {3'd3, 3'd4, 3'd1});
    check_eq("alu_waddr", last_waddr, 2);
    check_eq("alu_pc", pc, 1);
    repeat (4) tick();
    check_eq("halt_halted", halted, 1);
    check_eq("halt_illegal", illegal, 0);

    // LDI r5,#0xBEEF with 3-cycle ack delay, then zero-wait for latency
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      mem[0] = 16'h8A00; mem[1] = 16'hBEEF;
      ack_min = (pass == 0) ? 3 : 0; ack_max = ack_min;
      do_reset();
      run = 1'b1;
      wait_wr(1, 60);
      check_eq("ldi_bus", last_bus, 16'hBEEF);
      check_eq("ldi_en_d", last_en_d, 1);
      check_eq("ldi_waddr", last_waddr, 5);
      check_eq("ldi_pc", pc, 2);
      if (pass == 1) check_eq("ldi_lat", wr_tick - ack_tick + 1, 4);
    end

    // BZ taken / not taken
    bz_case(1'b1, 16'h0040);
    bz_case(1'b0, 16'h0003);

    // Illegal opcode 0xC
    clear_mem();
    mem[0] = 16'hC000;
    do_reset();
    run = 1'b1;
    repeat (6) tick();
    check_eq("ill_halted", halted, 1);
    check_eq("ill_illegal", illegal, 1);
    repeat (4) tick();
    check_eq("ill_req", imem_req, 0);
    do_reset();
    check_eq("ill_clr_halted", halted, 0);
    check_eq("ill_clr_illegal", illegal, 0);
    check_eq("ill_clr_pc", pc, 0);

    // PC wrap: JMP 0xFFFF, ALU op there, pc rolls to 0
    clear_mem();
    mem[0] = 16'hA000; mem[1] = 16'hFFFF; mem[8'hFF] = 16'h14E0;
    do_reset();
    run = 1'b1;
    wait_wr(1, 40);
    check_eq("wrap_pc", pc, 0);

    // Reset while a fetch is being acknowledged
    clear_mem();
    mem[0] = 16'h14E0;
    do_reset();
    run = 1'b1;
    tick();
    check_eq("mf_req", imem_req, 1);
    reset = 1'b1;
    tick();
    check_eq("mf_req_drop", imem_req, 0);
    check_eq("mf_pc", pc, 0);
    reset = 1'b0;
    run = 1'b0;
    model_reset();

    // Random programs with random ack delays and z_flag
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 16'($urandom);
        mem[i][15:12] = 4'($urandom_range(10, 0));
      end
      ack_min = 0; ack_max = 3; z_rand = 1'b1;
      do_reset();
      run = 1'b1;
      repeat (1500) tick();
      check_eq("rand_progress", wr_cnt > 50, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
